// File: rtl/inst_queue.sv
// Circular {inst, pc} FIFO between fetch and decode, with flush and full back-pressure.
// Optional macro IQ_BYPASS_EN: an empty queue forwards IF straight to ID in the same cycle.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_S,
    input  logic [31:0] IF_Inst,
    input  logic [31:0] IF_pc,
    output logic        IQ_Full,
    output logic        IQ_S,
    output logic [31:0] IQ_Inst,
    output logic [31:0] IQ_pc,
    input  logic        IQ_Success,
    input  logic        ROB_Clear
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       inst_mem_q [DEPTH];
    logic [31:0]       inst_mem_d [DEPTH];
    logic [31:0]       pc_mem_q   [DEPTH];
    logic [31:0]       pc_mem_d   [DEPTH];

    logic empty;
    logic full;
    logic bypass_vld;
    logic push;
    logic pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
`ifdef IQ_BYPASS_EN
        // Forwarding is only offered while the queue is able to act this cycle.
        bypass_vld = rdy & empty & IF_S & ~ROB_Clear;
`else
        bypass_vld = 1'b0;
`endif
        IQ_Full = full;
        IQ_S    = ~empty | bypass_vld;
        IQ_Inst = '0;
        IQ_pc   = '0;
        if (bypass_vld) begin
            IQ_Inst = IF_Inst;
            IQ_pc   = IF_pc;
        end else if (!empty) begin
            IQ_Inst = inst_mem_q[head_q];
            IQ_pc   = pc_mem_q[head_q];
        end
        // A forwarded entry that ID takes immediately never touches the array.
        push = IF_S & ~full & ~(bypass_vld & IQ_Success);
        pop  = ~empty & IQ_Success;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (rdy) begin
            if (ROB_Clear) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    inst_mem_d[tail_q] = IF_Inst;
                    pc_mem_d[tail_q]   = IF_pc;
                    tail_d             = tail_q + 1'b1;
                end
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue; build with +define+IQ_BYPASS_EN to check the bypass variant.
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_S;
    logic [31:0] IF_Inst;
    logic [31:0] IF_pc;
    logic        IQ_Full;
    logic        IQ_S;
    logic [31:0] IQ_Inst;
    logic [31:0] IQ_pc;
    logic        IQ_Success;
    logic        ROB_Clear;

    int tests;
    int fails;

    inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .IF_S       (IF_S),
        .IF_Inst    (IF_Inst),
        .IF_pc      (IF_pc),
        .IQ_Full    (IQ_Full),
        .IQ_S       (IQ_S),
        .IQ_Inst    (IQ_Inst),
        .IQ_pc      (IQ_pc),
        .IQ_Success (IQ_Success),
        .ROB_Clear  (ROB_Clear)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tied to its pc: 0x0->0x13, 0x4->0x00100093, 0x8->0x00200113, ...
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0000_0013 + (pc >> 2) * 32'h0010_0080;
    endfunction

    // driver tasks
    task automatic set_in(input logic s, input logic [31:0] pc, input logic succ);
        IF_S       = s;
        IF_pc      = pc;
        IF_Inst    = inst_of(pc);
        IQ_Success = succ;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; ROB_Clear = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        #1;
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL reset_iq_s: got %b want 0", IQ_S); end
        tests++; if (IQ_Full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", IQ_Full); end
        tests++; if (IQ_Inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", IQ_Inst); end
        tests++; if (IQ_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", IQ_pc); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(i * 4), 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b1) begin fails++; $display("FAIL basic_iq_s: got %b want 1", IQ_S); end
        tests++; if (IQ_Inst !== 32'h0000_0013) begin fails++; $display("FAIL basic_head_inst: got %h want 00000013", IQ_Inst); end
        tests++; if (IQ_pc !== 32'h0) begin fails++; $display("FAIL basic_head_pc: got %h want 0", IQ_pc); end
        tests++; if (IQ_Full !== 1'b0) begin fails++; $display("FAIL basic_full: got %b want 0", IQ_Full); end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b1);
            tests++; if (IQ_pc !== 32'(i * 4)) begin fails++; $display("FAIL basic_pop_pc: got %h want %h", IQ_pc, 32'(i * 4)); end
            tests++; if (IQ_Inst !== inst_of(32'(i * 4))) begin fails++; $display("FAIL basic_pop_inst: got %h want %h", IQ_Inst, inst_of(32'(i * 4))); end
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b want 0", IQ_S); end
        tests++; if (IQ_pc !== 32'h0) begin fails++; $display("FAIL basic_drained_pc: got %h want 0", IQ_pc); end
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 32'h10, 1'b0);
        tick();
        set_in(1'b1, 32'h14, 1'b1);
        tests++; if (IQ_pc !== 32'h10) begin fails++; $display("FAIL b2b_first: got %h want 00000010", IQ_pc); end
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h14) begin fails++; $display("FAIL b2b_second: got s=%b pc=%h want s=1 pc=00000014", IQ_S, IQ_pc); end
        set_in(1'b0, 32'h0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", IQ_S); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 32'(i * 4), 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_Full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b want 1", IQ_Full); end
        set_in(1'b1, 32'h40, 1'b0);
        tick();
        tests++; if (IQ_Full !== 1'b1 || IQ_pc !== 32'h0) begin fails++; $display("FAIL full_ignore_push: got full=%b pc=%h want full=1 pc=0", IQ_Full, IQ_pc); end
        // Pop while full with IF still presenting: the push must be dropped.
        set_in(1'b1, 32'h40, 1'b1);
        tests++; if (IQ_pc !== 32'h0) begin fails++; $display("FAIL full_pop0: got %h want 0", IQ_pc); end
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_Full !== 1'b0) begin fails++; $display("FAIL full_after_pop: got %b want 0", IQ_Full); end
        for (int i = 1; i < 16; i++) begin
            set_in(1'b0, 32'h0, 1'b1);
            tests++; if (IQ_pc !== 32'(i * 4)) begin fails++; $display("FAIL full_drain_pc: got %h want %h", IQ_pc, 32'(i * 4)); end
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0 || IQ_Full !== 1'b0) begin fails++; $display("FAIL full_drained: got s=%b full=%b want 0 0", IQ_S, IQ_Full); end
    endtask

    task automatic test_wrap();
        int in_n;
        int out_n;
        in_n = 0;
        out_n = 0;
        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, 32'h1000 + 32'(in_n * 4), 1'b0);
            tick();
            in_n++;
        end
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 32'h1000 + 32'(in_n * 4), 1'b1);
            tests++; if (IQ_pc !== 32'h1000 + 32'(out_n * 4) || IQ_Full !== 1'b0) begin fails++; $display("FAIL wrap_stream: got pc=%h full=%b want pc=%h full=0", IQ_pc, IQ_Full, 32'h1000 + 32'(out_n * 4)); end
            tick();
            in_n++;
            out_n++;
        end
        for (int i = 0; i < 15; i++) begin
            set_in(1'b0, 32'h0, 1'b1);
            tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h1000 + 32'(out_n * 4)) begin fails++; $display("FAIL wrap_drain: got s=%b pc=%h want s=1 pc=%h", IQ_S, IQ_pc, 32'h1000 + 32'(out_n * 4)); end
            tick();
            out_n++;
        end
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL wrap_empty: got %b want 0", IQ_S); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h500 + 32'(i * 4), 1'b0);
            tick();
        end
        set_in(1'b1, 32'h100, 1'b1);
        ROB_Clear = 1'b1;
        tick();
        ROB_Clear = 1'b0;
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL clear_iq_s: got %b want 0", IQ_S); end
        tests++; if (IQ_Inst !== 32'h0 || IQ_pc !== 32'h0) begin fails++; $display("FAIL clear_head: got inst=%h pc=%h want 0 0", IQ_Inst, IQ_pc); end
        set_in(1'b1, 32'h200, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h200 || IQ_Inst !== inst_of(32'h200)) begin fails++; $display("FAIL clear_next_push: got s=%b pc=%h inst=%h want s=1 pc=00000200", IQ_S, IQ_pc, IQ_Inst); end
        set_in(1'b0, 32'h0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL clear_single_entry: got %b want 0", IQ_S); end
    endtask

    task automatic test_rdy_reset();
        set_in(1'b1, 32'h300, 1'b0);
        tick();
        set_in(1'b1, 32'h304, 1'b0);
        tick();
        rdy = 1'b0;
        set_in(1'b1, 32'h308, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h300) begin fails++; $display("FAIL rdy_freeze: got s=%b pc=%h want s=1 pc=00000300", IQ_S, IQ_pc); end
        end
        rdy = 1'b1;
        set_in(1'b0, 32'h0, 1'b1);
        tests++; if (IQ_pc !== 32'h300) begin fails++; $display("FAIL rdy_pop0: got %h want 00000300", IQ_pc); end
        tick();
        tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h304) begin fails++; $display("FAIL rdy_pop1: got s=%b pc=%h want s=1 pc=00000304", IQ_S, IQ_pc); end
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL rdy_count2: got %b want 0", IQ_S); end
        set_in(1'b1, 32'h400, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        tests++; if (IQ_S !== 1'b0 || IQ_pc !== 32'h0) begin fails++; $display("FAIL async_reset: got s=%b pc=%h want s=0 pc=0", IQ_S, IQ_pc); end
        #2;
        rst = 1'b0;
        tick();
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL post_reset: got %b want 0", IQ_S); end
    endtask

    task automatic test_empty_latency();
        set_in(1'b1, 32'h80, 1'b1);
        #1;
`ifdef IQ_BYPASS_EN
        tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h80) begin fails++; $display("FAIL bypass_same_cycle: got s=%b pc=%h want s=1 pc=00000080", IQ_S, IQ_pc); end
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL bypass_not_stored: got %b want 0", IQ_S); end
`else
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL nobypass_same_cycle: got %b want 0", IQ_S); end
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b1 || IQ_pc !== 32'h80) begin fails++; $display("FAIL nobypass_next_cycle: got s=%b pc=%h want s=1 pc=00000080", IQ_S, IQ_pc); end
        set_in(1'b0, 32'h0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0);
        tests++; if (IQ_S !== 1'b0) begin fails++; $display("FAIL nobypass_drained: got %b want 0", IQ_S); end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_wrap();
        test_clear();
        test_rdy_reset();
        test_empty_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
